// File: rtl/matrix_vector_multiplier.sv
// Signed N x N matrix times N-vector: one result row per clock through N multipliers and an adder tree.
// Define MVM_SATURATE_EN to clamp each result element instead of wrapping it to WIDTH bits.
module matrix_vector_multiplier #(
   parameter int N     = 3,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ena,
   input  logic [N*N*WIDTH-1:0]   matrix_a,
   input  logic [N*WIDTH-1:0]     vector_b,
   output logic [N*WIDTH-1:0]     vector_c,
   output logic                   done,
   output logic [1:0]             o_dbg_state
);

   localparam int ACC_W = 2*WIDTH + $clog2(N);
   localparam int ROW_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N-1);

`ifdef MVM_SATURATE_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t                    r_state;
   logic [ROW_W-1:0]          r_row;
   logic signed [WIDTH-1:0]   r_a [N][N];
   logic signed [WIDTH-1:0]   r_b [N];
   logic [WIDTH-1:0]          r_c [N];
   logic                      r_done;

   logic signed [WIDTH-1:0]   w_in_a [N][N];
   logic signed [WIDTH-1:0]   w_in_b [N];
   logic signed [2*WIDTH-1:0] w_prod [N];
   logic signed [ACC_W-1:0]   w_acc;
   logic [WIDTH-1:0]          w_res;

   // Unpack the MSB-first flattened buses: element 0 lives in the top bits.
   for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign w_in_b[gi] = vector_b[(N-1-gi)*WIDTH +: WIDTH];
      assign vector_c[(N-1-gi)*WIDTH +: WIDTH] = r_c[gi];
      for (genvar gj = 0; gj < N; gj++) begin : g_col
         assign w_in_a[gi][gj] = matrix_a[(N*N-1-(gi*N+gj))*WIDTH +: WIDTH];
      end
   end

   // Full-precision dot product of the current row with the captured vector.
   always_comb begin
      w_prod = '{default: '0};
      w_acc  = '0;
      for (int j = 0; j < N; j++) begin
         w_prod[j] = (2*WIDTH)'(r_a[r_row][j]) * (2*WIDTH)'(r_b[j]);
         w_acc     = w_acc + ACC_W'(w_prod[j]);
      end
   end

   always_comb begin
      w_res = w_acc[WIDTH-1:0];
`ifdef MVM_SATURATE_EN
      if (w_acc > SAT_MAX) begin
         w_res = SAT_MAX[WIDTH-1:0];
      end else if (w_acc < SAT_MIN) begin
         w_res = SAT_MIN[WIDTH-1:0];
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_row   <= '0;
         r_done  <= 1'b0;
         for (int i = 0; i < N; i++) begin
            r_b[i] <= '0;
            r_c[i] <= '0;
            for (int j = 0; j < N; j++) begin
               r_a[i][j] <= '0;
            end
         end
      end else begin
         case (r_state)
            IDLE, DONE: begin
               // Capturing the operands decouples the run from later input changes.
               if (ena) begin
                  for (int i = 0; i < N; i++) begin
                     r_b[i] <= w_in_b[i];
                     for (int j = 0; j < N; j++) begin
                        r_a[i][j] <= w_in_a[i][j];
                     end
                  end
                  r_row   <= '0;
                  r_done  <= 1'b0;
                  r_state <= COMPUTE;
               end
            end
            COMPUTE: begin
               r_c[r_row] <= w_res;
               if (r_row == LAST_ROW) begin
                  r_row   <= '0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_row <= r_row + ROW_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign done        = r_done;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_matrix_vector_multiplier.sv
// Directed and random bench for matrix_vector_multiplier (N=3, WIDTH=8) with an expected-result queue.
module tb_matrix_vector_multiplier;

   localparam int N = 3;
   localparam int W = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ena = 1'b0;
   logic [71:0]   matrix_a = '0;
   logic [23:0]   vector_b = '0;
   logic [23:0]   vector_c;
   logic          done;
   logic [1:0]    dbg_state;

   logic [23:0]   exp_q[$];
   int            n_vec = 0;
   int            n_err = 0;

`ifdef MVM_SATURATE_EN
   localparam logic [23:0] EXP_28 = 24'h80817F;
   localparam logic [23:0] EXP_29 = 24'hCC7FE7;
`else
   localparam logic [23:0] EXP_28 = 24'hFD8103;
   localparam logic [23:0] EXP_29 = 24'hCC8CE7;
`endif

   always #5 clk = ~clk;

   matrix_vector_multiplier #(.N(N), .WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .matrix_a    (matrix_a),
      .vector_b    (vector_b),
      .vector_c    (vector_c),
      .done        (done),
      .o_dbg_state (dbg_state)
   );

   function automatic logic [23:0] pack3(input int x0, input int x1, input int x2);
      return {8'(x0), 8'(x1), 8'(x2)};
   endfunction

   function automatic logic [23:0] model(input logic [71:0] a, input logic [23:0] b);
      logic [23:0] c;
      int acc, x, y;
      c = '0;
      for (int i = 0; i < 3; i++) begin
         acc = 0;
         for (int j = 0; j < 3; j++) begin
            x = $signed(a[(8-(i*3+j))*8 +: 8]);
            y = $signed(b[(2-j)*8 +: 8]);
            acc = acc + x * y;
         end
`ifdef MVM_SATURATE_EN
         if (acc > 127) acc = 127;
         if (acc < -128) acc = -128;
`endif
         c[(2-i)*8 +: 8] = 8'(acc);
      end
      return c;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic drive_start(input logic [71:0] a, input logic [23:0] b,
                              input bit push, input logic [23:0] expv);
      ena      = 1'b1;
      matrix_a = a;
      vector_b = b;
      if (push) exp_q.push_back(expv);
      @(posedge clk); #1;
      ena = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int lat, input bit scramble);
      int n;
      logic [23:0] e;
      n = 0;
      while (done !== 1'b1 && n < 12) begin
         if (scramble) begin
            matrix_a = {8'($urandom), 32'($urandom), 32'($urandom)};
            vector_b = 24'($urandom);
         end
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'(lat));
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
      check({tag, "_vector_c"}, 32'(vector_c), 32'(e));
   endtask

   logic [71:0] a_inc, a_id, a_big, a_28, a_29, a_r;
   logic [23:0] b_r;
   logic        seen;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "bench timeout");
   end

   initial begin
      a_inc = {pack3(1, 2, 3), pack3(4, 5, 6), pack3(7, 8, 9)};
      a_id  = {pack3(1, 0, 0), pack3(0, 1, 0), pack3(0, 0, 1)};
      a_big = {pack3(33, 22, 85), pack3(11, 99, 45), pack3(77, 66, 19)};
      a_28  = {pack3(-127, -127, -127), pack3(-1, -1, 1), pack3(127, 127, 127)};
      a_29  = {pack3(10, -3, 5), pack3(-8, 12, 0), pack3(7, 1, -2)};

      // reset state
      #1;
      check("reset_done", 32'(done), 32'(0));
      check("reset_vector_c", 32'(vector_c), 32'(0));
      check("reset_state", 32'(dbg_state), 32'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // basic run
      drive_start(a_inc, pack3(1, 2, 3), 1'b1, 24'h0E2032);
      wait_done("basic", 3, 1'b0);

      // start from DONE: done drops, untouched rows hold old values
      drive_start(a_id, pack3(2, 7, 99), 1'b1, 24'h020763);
      check("restart_done_drop", 32'(done), 32'(0));
      check("restart_hold", 32'(vector_c), 32'h0E2032);
      @(posedge clk); #1;
      check("restart_row0_only", 32'(vector_c), 32'h022032);
      wait_done("identity", 2, 1'b0);

      drive_start(a_big, pack3(0, 0, 0), 1'b1, 24'h000000);
      wait_done("zero_b", 3, 1'b0);

      // inputs scrambled during COMPUTE
      drive_start(a_29, pack3(-4, 9, 3), 1'b1, EXP_29);
      wait_done("scramble", 3, 1'b1);

      drive_start(a_28, pack3(127, 127, 127), 1'b1, EXP_28);
      wait_done("overflow", 3, 1'b0);

      // ena held high: back-to-back runs, done high one cycle in between
      ena      = 1'b1;
      matrix_a = a_inc;
      vector_b = pack3(1, 2, 3);
      exp_q.push_back(24'h0E2032);
      exp_q.push_back(24'h0E2032);
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         check($sformatf("b2b_done_e%0d", k), 32'(done), 32'((k % 4) == 3));
         if ((k % 4) == 3) check($sformatf("b2b_vector_c_e%0d", k), 32'(vector_c), 32'(exp_q.pop_front()));
      end
      ena = 1'b0;
      @(posedge clk); #1;
      check("b2b_hold_done", 32'(done), 32'(1));
      check("b2b_hold_vector_c", 32'(vector_c), 32'h0E2032);

      // reset mid-COMPUTE aborts the run
      drive_start(a_29, pack3(-4, 9, 3), 1'b0, 24'h0);
      @(posedge clk); #1;
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_done", 32'(done), 32'(0));
      check("abort_vector_c", 32'(vector_c), 32'(0));
      check("abort_state", 32'(dbg_state), 32'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         seen = seen | done;
      end
      check("abort_no_done", 32'(seen), 32'(0));

      // first start after reset
      drive_start(a_29, pack3(-4, 9, 3), 1'b1, EXP_29);
      wait_done("post_reset", 3, 1'b0);

      for (int r = 0; r < 4; r++) begin
         a_r = {8'($urandom), 32'($urandom), 32'($urandom)};
         b_r = 24'($urandom);
         drive_start(a_r, b_r, 1'b1, model(a_r, b_r));
         wait_done($sformatf("random%0d", r), 3, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
